// File: rtl/cam_fb_writer_pkg.sv
// Shared types and defaults for the camera framebuffer writer.
// The double-buffer feature is enabled by defining CAM_FB_DOUBLE_BUF_EN.
package cam_pkg;

  typedef enum logic [1:0] {WAIT_LOW, WAIT_HIGH, CAPTURE, DONE} t_fb_state;

  typedef logic [15:0] rgb565_t;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  function automatic int unsigned decim_shift(input int unsigned decim);
    return (decim == 4) ? 2 : (decim == 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/cam_fb_writer_if.sv
// Pixel stream from the capture stage and BRAM write port toward the framebuffer.
// Bank selection in wr_bank only moves when CAM_FB_DOUBLE_BUF_EN is defined.
interface cam_pix_if;
  import cam_pkg::*;
  logic       vsync;
  logic       valid;
  rgb565_t    data;
  logic [9:0] row;
  logic [9:0] col;

  modport master (output vsync, valid, data, row, col);
  modport slave  (input  vsync, valid, data, row, col);
endinterface

interface fb_wr_if #(parameter int ADDR_W = 19);
  import cam_pkg::*;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  rgb565_t           wr_data;
  logic              wr_bank;

  modport master (output wr_en, wr_addr, wr_data, wr_bank);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_bank);
endinterface

// File: rtl/cam_fb_writer_decim_addr.sv
// Keep decision and framebuffer address generation for decimated capture.
// Row base advances by OUT_W per kept row; no multiplier in the address path.
module cam_decim_addr
  import cam_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_active,
  input  logic              i_valid,
  input  logic [9:0]        i_row,
  input  logic [9:0]        i_col,
  output logic              o_keep,
  output logic              o_oob,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int unsigned       SH       = decim_shift(DECIM);
  localparam logic [9:0]        LOW_MASK = 10'(DECIM - 1);
  localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(IMG_W / DECIM);

  logic [9:0]        row_dec, col_dec, cur_row_q;
  logic [ADDR_W-1:0] base_q, base;
  logic              in_range, on_grid;

  // Rows arrive in raster order, so a new kept row is always the previous one plus one.
  always_comb begin
    row_dec  = i_row >> SH;
    col_dec  = i_col >> SH;
    in_range = (32'(i_row) < 32'(IMG_H)) && (32'(i_col) < 32'(IMG_W));
    on_grid  = ((i_row & LOW_MASK) == '0) && ((i_col & LOW_MASK) == '0);
    o_keep   = i_active && i_valid && in_range && on_grid;
    o_oob    = i_active && i_valid && !in_range;
    base     = (row_dec == cur_row_q) ? base_q : base_q + OUT_W_A;
    o_addr   = base + ADDR_W'(col_dec);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cur_row_q <= '0;
      base_q    <= '0;
    end else if (o_keep) begin
      cur_row_q <= row_dec;
      base_q    <= base;
    end
  end

endmodule

// File: rtl/cam_fb_writer.sv
// Writes the camera RGB565 stream into a framebuffer with frame completion check.
// Define CAM_FB_DOUBLE_BUF_EN to enable the write/read bank swap on good frames.
module cam_fb_writer
  import cam_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DECIM  = 1,
  parameter int ADDR_W = 19
) (
  input  logic        i_clk,
  input  logic        i_rst,
  cam_pix_if.slave    pix,
  fb_wr_if.master     wr,
  input  logic        i_rd_lock,
  output logic        o_rd_bank,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic        o_overflow
);

  localparam logic [ADDR_W:0] TOTAL = (ADDR_W + 1)'((IMG_W / DECIM) * (IMG_H / DECIM));

  t_fb_state         state_q;
  logic [ADDR_W:0]   count_q;
  logic              wr_en_q, wr_bank_q, rd_bank_q;
  logic [ADDR_W-1:0] wr_addr_q, addr;
  rgb565_t           wr_data_q;
  logic              done_q, ok_q, ovf_q;
  logic              keep, oob, clr;

  assign clr = (state_q == WAIT_HIGH) && pix.vsync;

  cam_decim_addr #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DECIM  (DECIM),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (clr),
    .i_active ((state_q == CAPTURE) && pix.vsync),
    .i_valid  (pix.valid),
    .i_row    (pix.row),
    .i_col    (pix.col),
    .o_keep   (keep),
    .o_oob    (oob),
    .o_addr   (addr)
  );

`ifndef CAM_FB_DOUBLE_BUF_EN
  logic unused_rd_lock;
  assign unused_rd_lock = i_rd_lock;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= WAIT_LOW;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_en_q <= keep;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      if (keep) begin
        wr_addr_q <= addr;
        wr_data_q <= pix.data;
      end
      if (oob) ovf_q <= 1'b1;
      case (state_q)
        WAIT_LOW:  if (!pix.vsync) state_q <= WAIT_HIGH;
        WAIT_HIGH: if (pix.vsync) begin
          state_q <= CAPTURE;
          count_q <= '0;
        end
        CAPTURE: begin
          // Saturate so duplicated pixels cannot wrap the count into a false match.
          if (keep && count_q != TOTAL) count_q <= count_q + 1'b1;
          if (!pix.vsync) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ok_q    <= (count_q == TOTAL);
          end
        end
        DONE: begin
          state_q <= WAIT_HIGH;
`ifdef CAM_FB_DOUBLE_BUF_EN
          if (ok_q && !i_rd_lock) begin
            wr_bank_q <= ~wr_bank_q;
            rd_bank_q <= wr_bank_q;
          end
`endif
        end
        default: state_q <= WAIT_LOW;
      endcase
    end
  end

  assign wr.wr_en      = wr_en_q;
  assign wr.wr_addr    = wr_addr_q;
  assign wr.wr_data    = wr_data_q;
  assign wr.wr_bank    = wr_bank_q;
  assign o_rd_bank     = rd_bank_q;
  assign o_frame_done  = done_q;
  assign o_frame_ok    = ok_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_cam_fb_writer.sv
// Scoreboard bench for cam_fb_writer: DECIM=1 4x2 and DECIM=2 8x4 instances.
// Bank expectations follow CAM_FB_DOUBLE_BUF_EN when it is defined.
module tb_cam_fb_writer;
  import cam_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cam_pix_if pix1();
  cam_pix_if pix2();
  fb_wr_if #(.ADDR_W(4)) wr1();
  fb_wr_if #(.ADDR_W(4)) wr2();

  logic lock1, lock2, rdb1, rdb2, done1, done2, ok1, ok2, ovf1, ovf2;

  cam_fb_writer #(.IMG_W(4), .IMG_H(2), .DECIM(1), .ADDR_W(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .pix(pix1), .wr(wr1), .i_rd_lock(lock1),
    .o_rd_bank(rdb1), .o_frame_done(done1), .o_frame_ok(ok1), .o_overflow(ovf1)
  );

  cam_fb_writer #(.IMG_W(8), .IMG_H(4), .DECIM(2), .ADDR_W(4)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .pix(pix2), .wr(wr2), .i_rd_lock(lock2),
    .o_rd_bank(rdb2), .o_frame_done(done2), .o_frame_ok(ok2), .o_overflow(ovf2)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         q1[$], q2[$];
  wr_t         e1, e2;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] d2_at7;
  bit          exp_wr[1:2];
  bit          exp_rd[1:2];

  // Write monitor: every BRAM write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (wr1.wr_en === 1'b1) begin
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL dut1_write got addr=%0d data=%h, required no write", wr1.wr_addr, wr1.wr_data);
        end else begin
          e1 = q1.pop_front();
          if (wr1.wr_addr !== e1.addr || wr1.wr_data !== e1.data) begin
            fails++;
            $display("FAIL dut1_write got addr=%0d data=%h, required addr=%0d data=%h",
                     wr1.wr_addr, wr1.wr_data, e1.addr, e1.data);
          end
        end
      end
      if (wr2.wr_en === 1'b1) begin
        tests++;
        if (wr2.wr_addr === 4'd7) d2_at7 = wr2.wr_data;
        if (q2.size() == 0) begin
          fails++;
          $display("FAIL dut2_write got addr=%0d data=%h, required no write", wr2.wr_addr, wr2.wr_data);
        end else begin
          e2 = q2.pop_front();
          if (wr2.wr_addr !== e2.addr || wr2.wr_data !== e2.data) begin
            fails++;
            $display("FAIL dut2_write got addr=%0d data=%h, required addr=%0d data=%h",
                     wr2.wr_addr, wr2.wr_data, e2.addr, e2.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int sel, input logic vs, input logic vld,
                         input logic [9:0] r, input logic [9:0] c, input logic [15:0] d);
    if (sel == 1) begin
      pix1.vsync = vs; pix1.valid = vld; pix1.row = r; pix1.col = c; pix1.data = d;
    end else begin
      pix2.vsync = vs; pix2.valid = vld; pix2.row = r; pix2.col = c; pix2.data = d;
    end
  endtask

  task automatic vsync_start(input int sel);
    set_pix(sel, 1'b0, 1'b0, '0, '0, '0);
    tick(); tick();
    set_pix(sel, 1'b1, 1'b0, '0, '0, '0);
    tick(); tick();
  endtask

  task automatic frame1(input int skip, input bit oob_px);
    logic [15:0] d;
    vsync_start(1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        d = 16'($urandom);
        if (r * 4 + c == skip) begin
          set_pix(1, 1'b1, 1'b0, 10'(r), 10'(c), d);
        end else begin
          set_pix(1, 1'b1, 1'b1, 10'(r), 10'(c), d);
          q1.push_back('{addr: 4'(r * 4 + c), data: d});
        end
        tick();
      end
    end
    if (oob_px) begin
      set_pix(1, 1'b1, 1'b1, 10'd0, 10'd4, 16'hdead);
      tick();
    end
    set_pix(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_done(input int sel, input logic exp_ok, input string name);
    logic seen = 1'b0;
    logic got_ok = 1'b0;
    logic lk;
    lk = (sel == 1) ? lock1 : lock2;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (((sel == 1) ? done1 : done2) === 1'b1) begin
        seen   = 1'b1;
        got_ok = (sel == 1) ? ok1 : ok2;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_done got no pulse in 20 cycles, required pulse", name);
    end else if (got_ok !== exp_ok) begin
      fails++;
      $display("FAIL %s_ok got %b, required %b", name, got_ok, exp_ok);
    end
    @(negedge clk);
    tests++;
    if (((sel == 1) ? done1 : done2) !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse got done still 1, required 0", name);
    end
`ifdef CAM_FB_DOUBLE_BUF_EN
    if (exp_ok && !lk) begin
      exp_rd[sel] = exp_wr[sel];
      exp_wr[sel] = ~exp_wr[sel];
    end
`endif
    tests++;
    if (sel == 1 ? ({wr1.wr_bank, rdb1} !== {exp_wr[1], exp_rd[1]})
                 : ({wr2.wr_bank, rdb2} !== {exp_wr[2], exp_rd[2]})) begin
      fails++;
      $display("FAIL %s_banks got wr=%b rd=%b, required wr=%b rd=%b (lock=%b)", name,
               (sel == 1) ? wr1.wr_bank : wr2.wr_bank, (sel == 1) ? rdb1 : rdb2,
               exp_wr[sel], exp_rd[sel], lk);
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (q1.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d/%0d pending writes, required 0/0", name, q1.size(), q2.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pix(1, 1'b0, 1'b0, '0, '0, '0);
    set_pix(2, 1'b0, 1'b0, '0, '0, '0);
    lock1 = 1'b0; lock2 = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    tests++;
    if ({wr1.wr_en, wr1.wr_addr, wr1.wr_data, wr1.wr_bank, rdb1, done1, ok1, ovf1} !== '0) begin
      fails++;
      $display("FAIL reset_dut1 got en=%b addr=%0d data=%h wb=%b rb=%b done=%b ok=%b ovf=%b, required all 0",
               wr1.wr_en, wr1.wr_addr, wr1.wr_data, wr1.wr_bank, rdb1, done1, ok1, ovf1);
    end
    tests++;
    if ({wr2.wr_en, wr2.wr_addr, wr2.wr_data, wr2.wr_bank, rdb2, done2, ok2, ovf2} !== '0) begin
      fails++;
      $display("FAIL reset_dut2 got en=%b addr=%0d data=%h wb=%b rb=%b done=%b ok=%b ovf=%b, required all 0",
               wr2.wr_en, wr2.wr_addr, wr2.wr_data, wr2.wr_bank, rdb2, done2, ok2, ovf2);
    end
    tick();
    rst = 1'b0;
    exp_wr[1] = 1'b0; exp_rd[1] = 1'b0; exp_wr[2] = 1'b0; exp_rd[2] = 1'b0;
  endtask

  task automatic test_full_frame();
    frame1(-1, 1'b0);
    wait_done(1, 1'b1, "full_d1");
    check_drained("full_d1");
  endtask

  task automatic test_decim2();
    logic [15:0] d, exp7;
    exp7 = '0;
    vsync_start(2);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        d = 16'($urandom);
        set_pix(2, 1'b1, 1'b1, 10'(r), 10'(c), d);
        if (r % 2 == 0 && c % 2 == 0) q2.push_back('{addr: 4'((r / 2) * 4 + c / 2), data: d});
        if (r == 2 && c == 6) exp7 = d;
        tick();
      end
    end
    set_pix(2, 1'b0, 1'b0, '0, '0, '0);
    wait_done(2, 1'b1, "decim2");
    check_drained("decim2");
    tests++;
    if (d2_at7 !== exp7) begin
      fails++;
      $display("FAIL decim2_addr7 got data=%h, required %h", d2_at7, exp7);
    end
  endtask

  task automatic test_bank_swap();
    lock1 = 1'b0;
    frame1(-1, 1'b0);
    wait_done(1, 1'b1, "swap_unlocked");
    lock1 = 1'b1;
    frame1(-1, 1'b0);
    wait_done(1, 1'b1, "swap_locked");
    lock1 = 1'b0;
    check_drained("swap");
  endtask

  task automatic test_missing_pixel();
    frame1(5, 1'b0);
    wait_done(1, 1'b0, "missing");
    check_drained("missing");
  endtask

  task automatic test_reset_mid_frame();
    bit bad = 1'b0;
    vsync_start(1);
    for (int c = 0; c < 3; c++) begin
      set_pix(1, 1'b1, 1'b1, 10'd0, 10'(c), 16'(16'h100 + c));
      q1.push_back('{addr: 4'(c), data: 16'(16'h100 + c)});
      tick();
    end
    set_pix(1, 1'b1, 1'b0, '0, '0, '0);
    tick(); tick();
    check_drained("midrst_pre");
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_wr[1] = 1'b0; exp_rd[1] = 1'b0; exp_wr[2] = 1'b0; exp_rd[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_pix(1, 1'b1, 1'b1, 10'd0, 10'(i % 4), 16'hbeef);
      @(negedge clk);
      if (wr1.wr_en !== 1'b0 || done1 !== 1'b0) bad = 1'b1;
      tick();
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL midrst_hold got a write or done while vsync stayed high, required none");
    end
    frame1(-1, 1'b0);
    wait_done(1, 1'b1, "midrst_next");
    check_drained("midrst");
  endtask

  task automatic test_overflow();
    frame1(-1, 1'b1);
    wait_done(1, 1'b1, "ovf_frame");
    tests++;
    if (ovf1 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set got %b, required 1", ovf1);
    end
    frame1(-1, 1'b0);
    wait_done(1, 1'b1, "ovf_next");
    tests++;
    if (ovf1 !== 1'b1 || ovf2 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky got dut1=%b dut2=%b, required 1 and 0", ovf1, ovf2);
    end
    check_drained("ovf");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_decim2();
    test_bank_swap();
    test_missing_pixel();
    test_reset_mid_frame();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
